// File: rtl/shift_pkg.sv
// Shared constants, state encoding and lane helpers for the shift_frame_tx / shift_align pair.
package shift_pkg;

  localparam int LANES  = 16;
  localparam int WORD_W = 16;
  localparam int LANE_W = $clog2(LANES);
  localparam int BUS_W  = LANES * WORD_W;

  localparam logic [WORD_W-1:0] SYNC_WORD = 16'h817E;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD
  } state_t;

  // Lowest bit of lane k on the flattened bus.
  function automatic int unsigned lane_lsb(input int unsigned lane);
    return lane * WORD_W;
  endfunction

endpackage

// File: rtl/shift_frame_tx_if.sv
// Payload handshake plus lane-bus outputs of the framer; master is the payload source / bus observer.
interface shift_frame_tx_if;
  import shift_pkg::*;

  logic [WORD_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [BUS_W-1:0]  dataout;
  logic [LANES-1:0]  valid_out;
  logic              frame_start;

  modport master (
    output din, din_valid,
    input  din_ready, dataout, valid_out, frame_start
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dataout, valid_out, frame_start
  );

endinterface

// File: rtl/lane_demux.sv
// Registers one word and its valid onto the selected lane; every other lane is driven to zero.
module lane_demux
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_valid,
  output logic [BUS_W-1:0]  o_dataout,
  output logic [LANES-1:0]  o_valid
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic              w_hit;
      logic [WORD_W-1:0] r_data;
      logic              r_valid;

      assign w_hit = i_valid && (i_lane == LANE_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_data  <= w_hit ? i_word : '0;
          r_valid <= w_hit;
        end
      end

      assign o_dataout[lane_lsb(gi) +: WORD_W] = r_data;
      assign o_valid[gi]                       = r_valid;
    end
  endgenerate

endmodule

// File: rtl/shift_frame_tx.sv
// Lane framer: preamble of sync words after enable, then FRAME_LEN payload words per frame,
// each later frame led by a single sync word on a freshly sampled lane.
module shift_frame_tx
  import shift_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int SYNC_REPS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [LANE_W-1:0] i_lane_sel,
  output logic              o_busy,
  shift_frame_tx_if.slave   bus
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PRE_W = (SYNC_REPS > 1) ? $clog2(SYNC_REPS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_LEN - 1);
  localparam logic [PRE_W-1:0] LAST_PRE  = PRE_W'(SYNC_REPS - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [PRE_W-1:0]  r_pre_cnt;
  logic [LANE_W-1:0] r_cur_lane;
  logic              r_frame_start;

  logic              w_handshake;
  logic [LANE_W-1:0] w_lane;
  logic [WORD_W-1:0] w_word;
  logic              w_valid;
  logic              w_start;

  assign w_handshake = bus.din_valid && (r_state == PAYLOAD);

  // The SYNC word already travels on the lane being latched this cycle.
  always_comb begin
    w_lane  = r_cur_lane;
    w_word  = '0;
    w_valid = 1'b0;
    w_start = 1'b0;
    case (r_state)
      PREAMBLE: begin
        w_word  = SYNC_WORD;
        w_valid = 1'b1;
        w_start = (r_pre_cnt == '0);
      end
      SYNC: begin
        w_lane  = i_lane_sel;
        w_word  = SYNC_WORD;
        w_valid = 1'b1;
        w_start = 1'b1;
      end
      PAYLOAD: begin
        if (w_handshake) begin
          w_word  = bus.din;
          w_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_word_cnt    <= '0;
      r_pre_cnt     <= '0;
      r_cur_lane    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_start;
      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_cur_lane <= i_lane_sel;
            r_pre_cnt  <= '0;
            r_state    <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          if (r_pre_cnt == LAST_PRE) begin
            r_pre_cnt  <= '0;
            r_word_cnt <= '0;
            r_state    <= PAYLOAD;
          end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
          end
        end
        SYNC: begin
          r_cur_lane <= i_lane_sel;
          r_word_cnt <= '0;
          r_state    <= PAYLOAD;
        end
        PAYLOAD: begin
          if (w_handshake) begin
            if (r_word_cnt == LAST_WORD) begin
              r_word_cnt <= '0;
              r_state    <= i_enable ? SYNC : IDLE;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy          = (r_state != IDLE);
  assign bus.din_ready   = (r_state == PAYLOAD);
  assign bus.frame_start = r_frame_start;

  lane_demux u_lane_demux (
    .clk       (clk),
    .rst       (rst),
    .i_lane    (w_lane),
    .i_word    (w_word),
    .i_valid   (w_valid),
    .o_dataout (bus.dataout),
    .o_valid   (bus.valid_out)
  );

endmodule

// File: tb/tb_shift_frame_tx.sv
// Scoreboard bench for shift_frame_tx: expected lane words are queued as stimulus is driven
// and popped whenever the lane bus shows a valid word.
module tb_shift_frame_tx;
  import shift_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [LANE_W-1:0] lane_sel = '0;
  logic             busy;

  shift_frame_tx_if io ();

  shift_frame_tx #(.FRAME_LEN(16), .SYNC_REPS(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (enable),
    .i_lane_sel (lane_sel),
    .o_busy     (busy),
    .bus        (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] word;
    logic              start;
  } exp_t;

  exp_t              sb[$];
  int                n_checks = 0;
  int                n_err    = 0;
  bit                mon_en   = 1'b0;
  logic [LANE_W-1:0] tb_lane  = '0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [LANE_W-1:0] lane, input logic [WORD_W-1:0] word,
                                   input logic start);
    exp_t e;
    e.lane  = lane;
    e.word  = word;
    e.start = start;
    sb.push_back(e);
  endfunction

  function automatic void push_preamble(input logic [LANE_W-1:0] lane);
    for (int i = 0; i < 5; i++) push_exp(lane, SYNC_WORD, (i == 0));
  endfunction

  // Monitor: compare every valid lane word against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (io.valid_out != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 256'(io.valid_out), 256'(0));
        end else begin
          exp_t e;
          logic [255:0] exp_bus;
          logic [15:0]  exp_vld;
          e = sb.pop_front();
          exp_bus = 256'(e.word) << (WORD_W * int'(e.lane));
          exp_vld = 16'(1) << e.lane;
          $display("tx lane=%0d word=%04h start=%0b", e.lane, e.word, e.start);
          chk("valid_out", 256'(io.valid_out), 256'(exp_vld));
          chk("dataout", io.dataout, exp_bus);
          chk("frame_start", 256'(io.frame_start), 256'(e.start));
        end
      end else begin
        chk("gap_dataout", io.dataout, 256'(0));
        chk("gap_frame_start", 256'(io.frame_start), 256'(0));
      end
    end
  end

  // Drive one word and wait (bounded) until din_ready shows it will be taken at the next edge.
  task automatic wait_push(input logic [WORD_W-1:0] w);
    int n = 0;
    io.din       = w;
    io.din_valid = 1'b1;
    while (!io.din_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!io.din_ready) chk("ready_timeout", 256'(0), 256'(1));
    else               push_exp(tb_lane, w, 1'b0);
  endtask

  task automatic send_frame(input logic [WORD_W-1:0] base, input bit gap, input int switch_at,
                            input logic [LANE_W-1:0] new_lane, input int drop_at, input int sync_at);
    for (int i = 0; i < 16; i++) begin
      if (i == switch_at) lane_sel = new_lane;
      if (i == drop_at)   enable   = 1'b0;
      wait_push((i == sync_at) ? SYNC_WORD : base + WORD_W'(i));
      if (i == 15 && enable) begin
        push_exp(lane_sel, SYNC_WORD, 1'b1);
        tb_lane = lane_sel;
      end
      @(negedge clk); #1;
      if (gap && i != 15) begin
        io.din_valid = 1'b0;
        @(negedge clk); #1;
      end
    end
    io.din_valid = 1'b0;
  endtask

  initial begin
    int k;
    io.din       = '0;
    io.din_valid = 1'b0;

    // Reset, then idle with enable low.
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (20) begin
      @(negedge clk); #1;
      chk("idle_busy", 256'(busy), 256'(0));
      chk("idle_ready", 256'(io.din_ready), 256'(0));
      chk("idle_valid", 256'(io.valid_out), 256'(0));
    end

    // Preamble on lane 1; din_ready must rise on the 6th cycle.
    lane_sel = 4'd1;
    enable   = 1'b1;
    tb_lane  = 4'd1;
    push_preamble(4'd1);
    k = 0;
    while (!io.din_ready && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("ready_rise", 256'(k), 256'(6));
    chk("busy_run", 256'(busy), 256'(1));

    // Back-to-back frame, then a gapped frame with a mid-frame lane change and a sync-valued payload.
    send_frame(16'h0001, 1'b0, -1, 4'd0, -1, -1);
    send_frame(16'h0101, 1'b1, 4, 4'd3, -1, 7);
    // Frame on lane 3 with enable dropped mid-way: completes, no trailing sync.
    send_frame(16'h0201, 1'b0, -1, 4'd0, 8, -1);
    repeat (10) @(negedge clk);
    #1;
    chk("disable_busy", 256'(busy), 256'(0));
    chk("disable_ready", 256'(io.din_ready), 256'(0));
    chk("sb_drained", 256'(sb.size()), 256'(0));

    // Re-enable on lane 2: full preamble again, then reset mid-payload.
    lane_sel = 4'd2;
    enable   = 1'b1;
    tb_lane  = 4'd2;
    push_preamble(4'd2);
    for (int i = 0; i < 5; i++) begin
      wait_push(16'h0301 + 16'(i));
      @(negedge clk); #1;
    end
    chk("sb_before_rst", 256'(sb.size()), 256'(0));
    io.din_valid = 1'b1;
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_dataout", io.dataout, 256'(0));
    chk("rst_valid", 256'(io.valid_out), 256'(0));
    chk("rst_frame_start", 256'(io.frame_start), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_ready", 256'(io.din_ready), 256'(0));
    sb.delete();
    io.din_valid = 1'b0;
    enable       = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_busy", 256'(busy), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_frame_tx.md
Name: shift_frame_tx

Overview:
Transmit-side framer that pairs with the shift_align lane receiver. It takes one 16-bit payload stream with a valid/ready handshake and drives it onto one selected lane of the 16-lane, 256-bit bus. Each frame starts with sync word 0x817E so the receiver can find and lock onto the lane. After enable, a preamble of repeated sync words is sent first to give the receiver time to lock.

Parameters:
LANES, 16, number of lanes on the bus
WORD_W, 16, bits per lane word
SYNC_WORD, 16'h817E, alignment word sent at each frame start
FRAME_LEN, 16, payload words per frame (>=1)
SYNC_REPS, 5, consecutive sync words in the preamble after enable (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  start framing; when dropped, the current frame finishes, then the block goes idle
lane_sel  in  4  lane to drive; sampled only at frame boundaries
din  in  16  payload word
din_valid  in  1  payload word available
din_ready  out  1  block accepts din this cycle
dataout  out  256  lane bus; lane k occupies bits [16k+15:16k]
valid_out  out  16  per-lane valid, one-hot or zero
frame_start  out  1  one-cycle pulse with the first sync word of each frame or preamble
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high) forces: state IDLE; dataout = 0; valid_out = 0; frame_start = 0; busy = 0; all counters 0. Reset applied mid-frame abandons the frame with no flush.
- dataout, valid_out and frame_start are registered. din_ready is combinational from state: high only in PAYLOAD.
- Latency: a word accepted at edge N (din_valid & din_ready) appears on the lane at the output after edge N, i.e. 1 cycle.
- Lanes other than cur_lane always carry data 0 with valid 0.
- State IDLE:
  - Outputs valid 0.
  - On enable = 1: latch lane_sel into cur_lane, go to PREAMBLE.
- State PREAMBLE:
  - Emit SYNC_WORD with valid on cur_lane every cycle, SYNC_REPS cycles total.
  - frame_start is asserted on the first of these words only.
  - Then go to PAYLOAD with word count 0.
- State PAYLOAD:
  - On each handshake, emit din on cur_lane with valid = 1 and increment the count.
  - Cycles without a handshake emit data 0, valid 0 and are not counted (gaps allowed).
  - When count reaches FRAME_LEN-1 and a handshake occurs: go to SYNC if enable = 1, else IDLE.
- State SYNC:
  - Emit SYNC_WORD with valid and frame_start = 1 for one cycle.
  - Re-latch cur_lane from lane_sel in this cycle; the sync word itself goes out on the newly latched lane.
  - Go to PAYLOAD with count 0.
- Boundary conditions:
  - lane_sel changes mid-frame are ignored until the next SYNC or IDLE exit.
  - enable dropped in PREAMBLE or SYNC does not stop the block; the following frame completes in full.
  - Re-enable while IDLE restarts with a full preamble.
  - Payload equal to SYNC_WORD is passed unmodified; no escaping. Alignment relies on frame position.
  - With FRAME_LEN = 1, PAYLOAD lasts exactly one accepted word.
- Widths: word counter is clog2(FRAME_LEN) bits, or 1 bit if FRAME_LEN = 1. Preamble counter is clog2(SYNC_REPS) bits, minimum 1. Neither counter wraps beyond its terminal value.

Decomposition:
- Shared package shift_pkg holds:
  - SYNC_WORD, LANES, WORD_W
  - the state enum {IDLE, PREAMBLE, SYNC, PAYLOAD}
  - a lane-index-to-bit-slice helper function
- shift_align reuses SYNC_WORD from shift_pkg.
- One natural sub-module, lane_demux: registered placement of a 16-bit word and its valid onto lane cur_lane, zero elsewhere. The FSM and counters stay in the top level.

Test Plan:
- Reset/idle: rst high for 4 cycles, enable = 0 → dataout = 0, valid_out = 0, busy = 0, din_ready = 0 for 20 cycles.
- Preamble: lane_sel = 1, enable = 1 → 5 cycles of bits [31:16] = 0x817E with valid_out = 16'h0002. frame_start is high on the first only. din_ready rises on cycle 6.
- Full frame: din_valid held high with din = 0x0001..0x0010 → 16 words on lane 1 in order at 1-cycle latency, then a single 0x817E with frame_start = 1, then the next payload.
- Gaps and lane switch: din_valid toggling 1,0,1,0 with lane_sel changed to 3 mid-frame → idle cycles have valid_out = 0 and are not counted. Lane 1 is used until the frame's 16th word; the next sync appears at bits [63:48] with valid_out = 16'h0008.
- Disable and reset:
  - enable dropped mid-frame → the remaining words are still accepted, then the block returns to IDLE with no trailing sync.
  - rst asserted mid-payload → outputs go to 0 immediately (asynchronously).
- Loopback: shift_frame_tx output feeds shift_align; payload 0xAAAA stream on lane 3 → shift_align valid asserts and dataout = 0xAAAA after lock.
